// File: rtl/man_cpa_pipe_pkg.sv
// man_cpa_pipe_pkg: mantissa width derivation and the 4-bit priority encoder shared by the CPA and LZC.
package man_cpa_pipe_pkg;
  function automatic int man_w(int sig_width);
    return 2 * (sig_width + 1) + 5;
  endfunction
  function automatic int lzc_w(int w);
    return $clog2(w + 1);
  endfunction
  function automatic logic [1:0] pri4(logic [3:0] a);
    return a[3] ? 2'd0 : a[2] ? 2'd1 : a[1] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/man_lzc.sv
// man_lzc: leading-zero counter for up to 63 bits, built as a three-level tree of 4-bit priority encoders.
module man_lzc
  import man_cpa_pipe_pkg::*;
#(
  parameter int W     = 53,
  parameter int LZC_W = 6
) (
  input  logic [W-1:0]     x,
  output logic [LZC_W-1:0] lzc,
  output logic             zero
);
  // A sentinel one just below x makes an all-zero input count to exactly W.
  logic [63:0] p;
  logic [15:0] v1;
  logic [1:0]  p1 [16];
  logic [3:0]  v2;
  logic [1:0]  p2 [4];
  logic [1:0]  p3, g2;
  logic [3:0]  g1;
  logic [5:0]  cnt;
  assign p = 64'({x, 1'b1}) << (63 - W);
  for (genvar g = 0; g < 16; g++) begin : g_l1
    assign v1[g] = |p[4*g+3 -: 4];
    assign p1[g] = pri4(p[4*g+3 -: 4]);
  end
  for (genvar g = 0; g < 4; g++) begin : g_l2
    assign v2[g] = |v1[4*g+3 -: 4];
    assign p2[g] = pri4(v1[4*g+3 -: 4]);
  end
  always_comb begin
    p3  = pri4(v2);
    g2  = 2'd3 - p3;
    g1  = {g2, 2'd3 - p2[g2]};
    cnt = {p3, p2[g2], p1[g1]};
  end
  assign lzc  = LZC_W'(cnt);
  assign zero = ~|x;
endmodule

// File: rtl/man_cpa_pipe.sv
// man_cpa_pipe: two-stage split carry-propagate adder resolving a sum/carry mantissa pair,
// with leading-zero count and zero flag on the output, behind an elastic valid/ready pipe.
module man_cpa_pipe
  import man_cpa_pipe_pkg::*;
#(
  parameter  int SIG_WIDTH = 23,
  parameter  int TAG_WIDTH = 4,
  localparam int MAN_W     = man_w(SIG_WIDTH),
  localparam int LZC_W     = lzc_w(MAN_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_W-1:0]     in_sum,
  input  logic [MAN_W-1:0]     in_carry,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_W-1:0]     out_man,
  output logic [LZC_W-1:0]     out_lzc,
  output logic                 out_zero,
  output logic [TAG_WIDTH-1:0] out_tag
);
  localparam int LO_W = MAN_W / 2;
  localparam int HI_W = MAN_W - LO_W;
  logic                 s1_valid, s2_valid, s1_cy, s1_adv, s2_adv;
  logic [LO_W-1:0]      s1_lo;
  logic [HI_W-1:0]      s1_hs, s1_hc;
  logic [TAG_WIDTH-1:0] s1_tag, s2_tag;
  logic [MAN_W-1:0]     s2_man;
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = rst_n && s1_adv;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_cy    <= 1'b0;
      s1_lo    <= '0;
      s1_hs    <= '0;
      s1_hc    <= '0;
      s1_tag   <= '0;
      s2_man   <= '0;
      s2_tag   <= '0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_man <= {s1_hs + s1_hc + HI_W'(s1_cy), s1_lo};
          s2_tag <= s1_tag;
        end
      end
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          {s1_cy, s1_lo} <= {1'b0, in_sum[LO_W-1:0]} + {1'b0, in_carry[LO_W-1:0]};
          s1_hs          <= in_sum[MAN_W-1:LO_W];
          s1_hc          <= in_carry[MAN_W-1:LO_W];
          s1_tag         <= in_tag;
        end
      end
    end
  end
  assign out_valid = s2_valid;
  assign out_man   = s2_man;
  assign out_tag   = s2_tag;
  man_lzc #(.W(MAN_W), .LZC_W(LZC_W)) u_lzc (
    .x   (s2_man),
    .lzc (out_lzc),
    .zero(out_zero)
  );
endmodule

// File: tb/tb_man_cpa_pipe.sv
// tb_man_cpa_pipe: directed and randomized checks of man_cpa_pipe against a queue-based sum/clz model.
module tb_man_cpa_pipe;
  localparam int MW = 53;
  localparam int LW = 6;
  localparam int TW = 4;
  logic          clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [MW-1:0] in_sum = '0, in_carry = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid, out_zero;
  logic [MW-1:0] out_man;
  logic [LW-1:0] out_lzc;
  logic [TW-1:0] out_tag;
  int errors = 0, checks = 0;
  typedef struct packed {logic [MW-1:0] man; logic [TW-1:0] tag;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  man_cpa_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_man(out_man),
    .out_lzc(out_lzc), .out_zero(out_zero), .out_tag(out_tag)
  );

  function automatic logic [MW-1:0] ref_sum(logic [MW-1:0] s, logic [MW-1:0] c);
    return s + c;
  endfunction

  function automatic int clz(logic [MW-1:0] v);
    for (int i = MW - 1; i >= 0; i--) if (v[i]) return MW - 1 - i;
    return MW;
  endfunction

  function automatic logic [MW-1:0] rnd();
    logic [63:0] r = {$urandom, $urandom};
    return MW'(r >> $urandom_range(0, 60));
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_man !== '0 || out_lzc !== LW'(MW) || out_zero !== 1'b1 ||
        out_tag !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b man=%h lzc=%0d zero=%b tag=%h in_ready=%b, want 0 0 53 1 0 0",
               out_valid, out_man, out_lzc, out_zero, out_tag, in_ready);
    end
    @(negedge clk) rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [MW-1:0] ss[3];
    logic [MW-1:0] cs[3];
    logic [MW-1:0] em[3];
    int            el[3];
    ss = '{53'd1, (53'd1 << 26) - 53'd1, {MW{1'b1}}};
    cs = '{53'd1, 53'd1, 53'd1};
    em = '{53'd2, 53'd1 << 26, 53'd0};
    el = '{51, 26, 53};
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1; in_sum = ss[k]; in_carry = cs[k]; in_tag = TW'(k + 3);
      @(negedge clk);
      in_valid = 0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single%0d early valid: got %b want 0", k, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_man !== em[k] || out_lzc !== LW'(el[k]) ||
          out_zero !== (em[k] == 0) || out_tag !== TW'(k + 3)) begin
        errors++;
        $display("FAIL single%0d: valid=%b man=%h lzc=%0d zero=%b tag=%0d, want 1 %h %0d %b %0d",
                 k, out_valid, out_man, out_lzc, out_zero, out_tag, em[k], el[k], em[k] == 0, k + 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int            sent = 0, got = 0;
    bit            stall = 0;
    logic [MW-1:0] hm = '0;
    q.delete();
    for (int cyc = 0; cyc < 60 && (sent < 8 || q.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid = sent < 8;
      in_sum = rnd(); in_carry = rnd(); in_tag = TW'($urandom);
      #1;
      checks++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        errors++;
        $display("FAIL b2b in_ready cyc=%0d: got %b want %b", cyc, in_ready, !(q.size() == 2 && !out_ready));
      end
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_man !== hm) begin
          errors++;
          $display("FAIL b2b hold cyc=%0d: valid=%b man=%h want 1 %h", cyc, out_valid, out_man, hm);
        end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || out_man !== q[0].man || out_tag !== q[0].tag ||
            out_lzc !== LW'(clz(q[0].man)) || out_zero !== (q[0].man == 0)) begin
          errors++;
          $display("FAIL b2b data cyc=%0d: man=%h tag=%0d lzc=%0d pending=%0d want man=%h tag=%0d",
                   cyc, out_man, out_tag, out_lzc, q.size(), q.size() ? q[0].man : '0, q.size() ? q[0].tag : '0);
        end
        if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      stall = out_valid && !out_ready;
      hm = out_man;
      if (in_valid && in_ready) begin
        q.push_back('{man: ref_sum(in_sum, in_carry), tag: in_tag});
        sent++;
      end
    end
    in_valid = 0;
    checks++;
    if (got != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b count: delivered=%0d pending=%0d want 8 0", got, q.size());
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    q.delete();
    out_ready = 0;
    @(negedge clk);
    in_valid = 1; in_sum = 53'd5; in_carry = 53'd6; in_tag = 4'd1;
    @(negedge clk);
    in_sum = 53'd7; in_carry = 53'd8; in_tag = 4'd2;
    @(negedge clk);
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midflight full: valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_lzc !== LW'(MW) || in_ready !== 1'b0 || out_zero !== 1'b1 || out_man !== '0) begin
      errors++;
      $display("FAIL midflight reset: valid=%b lzc=%0d in_ready=%b zero=%b man=%h want 0 53 0 1 0",
               out_valid, out_lzc, in_ready, out_zero, out_man);
    end
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 1; in_sum = 53'd100; in_carry = 53'd23; in_tag = 4'd9;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen++;
        checks++;
        if (out_man !== 53'd123 || out_tag !== 4'd9) begin
          errors++;
          $display("FAIL midflight after: man=%0d tag=%0d want 123 9", out_man, out_tag);
        end
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL midflight count: got %0d results want 1", seen);
    end
  endtask

  task automatic test_random();
    int            sent = 0, got = 0;
    bit            stall = 0;
    logic [MW-1:0] hm = '0;
    q.delete();
    for (int cyc = 0; cyc < 60000 && (sent < 10000 || q.size() > 0); cyc++) begin
      @(negedge clk);
      out_ready = $urandom_range(0, 3) != 0;
      in_valid = sent < 10000 && $urandom_range(0, 3) != 0;
      in_sum = rnd(); in_carry = rnd(); in_tag = TW'($urandom);
      #1;
      checks++;
      if (in_ready !== !(q.size() == 2 && !out_ready)) begin
        errors++;
        $display("FAIL rand in_ready cyc=%0d: got %b want %b", cyc, in_ready, !(q.size() == 2 && !out_ready));
      end
      if (stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_man !== hm) begin
          errors++;
          $display("FAIL rand hold cyc=%0d: valid=%b man=%h want 1 %h", cyc, out_valid, out_man, hm);
        end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || out_man !== q[0].man || out_tag !== q[0].tag ||
            out_lzc !== LW'(clz(q[0].man)) || out_zero !== (q[0].man == 0)) begin
          errors++;
          $display("FAIL rand data cyc=%0d: man=%h tag=%0d lzc=%0d pending=%0d want man=%h lzc=%0d",
                   cyc, out_man, out_tag, out_lzc, q.size(), q.size() ? q[0].man : '0, q.size() ? clz(q[0].man) : 0);
        end
        if (out_ready && q.size() > 0) begin
          void'(q.pop_front());
          got++;
        end
      end
      stall = out_valid && !out_ready;
      hm = out_man;
      if (in_valid && in_ready) begin
        q.push_back('{man: ref_sum(in_sum, in_carry), tag: in_tag});
        sent++;
      end
    end
    in_valid = 0;
    checks++;
    if (got != 10000 || q.size() != 0) begin
      errors++;
      $display("FAIL rand count: delivered=%0d pending=%0d want 10000 0", got, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/man_cpa_pipe.md
Name: man_cpa_pipe

Overview:
- Consumer of the redundant mantissa pair produced by the partial-product reduction tree, i.e. the final sum/carry vectors.
- Resolves the pair into a binary mantissa using a 2-stage pipelined split carry-propagate adder.
- Reports leading-zero count and zero flag for the downstream normaliser.
- Elastic valid/ready pipeline: full throughput, 2-cycle latency.

Parameters:
- SIG_WIDTH, 23, significand width excluding the hidden bit; sets MAN_W = 2*(SIG_WIDTH+1)+5 (53 by default).
- TAG_WIDTH, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_sum/in_carry/in_tag are valid.
- in_ready  out  1  block accepts the input this cycle.
- in_sum  in  MAN_W  redundant sum vector.
- in_carry  in  MAN_W  redundant carry vector, already aligned (no shift applied here).
- in_tag  in  TAG_WIDTH  sideband, passed through untouched.
- out_valid  out  1  outputs valid.
- out_ready  in  1  downstream accepts.
- out_man  out  MAN_W  (in_sum + in_carry) mod 2^MAN_W.
- out_lzc  out  LZC_W  leading zeros of out_man counted from the MSB; LZC_W = clog2(MAN_W+1).
- out_zero  out  1  out_man == 0.
- out_tag  out  TAG_WIDTH  tag of the same operation.

Behaviour:
- Split point: LO_W = MAN_W/2 (26 by default); HI_W = MAN_W-LO_W.
- Stage 1, on accept:
  - register s1_lo = in_sum[LO_W-1:0] + in_carry[LO_W-1:0], LO_W bits;
  - register s1_cy = carry-out of that add;
  - register the upper halves of in_sum and in_carry, and in_tag;
  - set s1_valid.
- Stage 2, on advance:
  - register s2_man = {hi_sum + hi_carry + s1_cy (mod 2^HI_W), s1_lo};
  - register the tag; set s2_valid.
  - Carry-out above MAN_W is discarded; no overflow flag.
- Outputs:
  - out_man = s2_man; out_valid = s2_valid; out_tag = s2 tag.
  - out_lzc and out_zero are combinational from s2_man.
  - s2_man == 0 gives out_lzc = MAN_W and out_zero = 1.
- Handshake and advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, and is held 0 while rst_n = 0.
- Transfers: input on in_valid & in_ready; output on out_valid & out_ready.
- Stage transfer:
  - When s2_adv is true, s2_valid takes s1_valid; s2 data loads only if s1_valid.
  - When s1_adv is true, s1_valid takes in_valid; s1 data loads only if in_valid.
- Latency: an input accepted in cycle N appears on the outputs at cycle N+2 when out_ready stays high.
- Throughput: one result per cycle, no bubbles.
- Backpressure and stability:
  - out_ready = 0 holds s2.
  - s1 holds once full; in_ready drops only when both stages are full and out_ready = 0.
  - Data, tag, lzc and zero stay stable while out_valid & !out_ready.
- Simultaneous events: a full pipe with out_ready = 1 and in_valid = 1 shifts everything by one in the same cycle; no loss, no duplication.
- Reset, including mid-operation: asynchronous clear of s1_valid, s2_valid, all data and tag registers. This gives out_valid = 0, out_man = 0, out_lzc = MAN_W, out_zero = 1, out_tag = 0. In-flight operations are dropped.
- No state machine beyond the two valid bits; the four pipe states {empty, s1 only, s2 only, full} follow the advance rules above.

Decomposition:
- Shared parameter include (existing parameters.v): MAN_W, LO_W, HI_W and LZC_W derived from SIG_WIDTH.
- One sub-module: man_lzc.
  - Combinational leading-zero counter, MAN_W-bit input, LZC_W-bit output, plus an all-zero flag.
  - Implemented as a tree of 4-bit priority encoders.
  - Reusable by the normaliser.

Test Plan:
- Single op, out_ready = 1: in_sum = 53'h1, in_carry = 53'h1, tag = 3 -> two cycles later out_man = 2, out_lzc = 51, out_zero = 0, out_tag = 3.
- Cross-half carry: in_sum = 2^26-1, in_carry = 1 -> out_man = 2^26, out_lzc = 26; checks that s1_cy propagates.
- Wrap and zero: in_sum = 2^53-1, in_carry = 1 -> out_man = 0, out_lzc = 53, out_zero = 1.
- Streaming plus backpressure:
  - Send 8 back-to-back ops and hold out_ready = 0 for cycles 3-6.
  - Required: in_ready = 0 only while both stages are full.
  - Required: results appear in order, exactly once, each equal to a reference sum mod 2^53.
- Reset mid-flight: async rst_n low with 2 ops in the pipe -> out_valid = 0 immediately, out_lzc = 53, in_ready = 0; after release the first new op completes correctly and no stale op appears.
- Random: 10k random sum/carry pairs with random in_valid/out_ready -> every out_man matches the model and out_lzc matches a software clz.
